mem_access_stage: RTL and testbench

//  Load/store stage that sits directly upstream of the 16-bit data memory (d_memory).

---
 rtl/mem_stage_pkg.sv | 18 +
 rtl/mem_byte_lane.sv | 21 ++
 rtl/mem_access_stage.sv | 96 +++++++++
 tb/tb_mem_access_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: op codes, FSM state encoding and default widths for the memory access stage
package mem_stage_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;
    typedef enum logic [1:0] {
        OP_LW = 2'b00,
        OP_SW = 2'b01,
        OP_LB = 2'b10,
        OP_SB = 2'b11
    } op_t;
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR
    } state_t;
endpackage

// File: rtl/mem_byte_lane.sv
// mem_byte_lane: byte extraction with optional sign extension and byte-lane merge for a 16-bit word
module mem_byte_lane
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] word,
    input  logic [7:0]        lane_byte,
    input  logic              hi,
    input  logic              sext,
    output logic [DATA_W-1:0] ext,
    output logic [DATA_W-1:0] merged
);
    logic [7:0] lane;
    // pick the addressed lane, extend it, and build the word with that lane replaced
    always_comb begin
        lane   = hi ? word[15:8] : word[7:0];
        ext    = {{(DATA_W-8){sext & lane[7]}}, lane};
        merged = hi ? {lane_byte, word[7:0]} : {word[15:8], lane_byte};
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: one-request-at-a-time load/store stage driving a combinational-read data memory
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int TAG_W     = 3,
    parameter bit LB_SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_hi,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [TAG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data
);
    state_t            state;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              hi_q;
    logic [DATA_W-1:0] wdata_q;
    logic [TAG_W-1:0]  rd_q;
    logic [DATA_W-1:0] merge_q;
    logic [DATA_W-1:0] lane_word;
    logic [DATA_W-1:0] lane_ext;
    logic [DATA_W-1:0] lane_merged;

    // the lane helper sees the captured word while merging, the live read data otherwise
    assign lane_word = (state == RMW_WR) ? merge_q : mem_rdata;

    mem_byte_lane #(.DATA_W(DATA_W)) u_lane (
        .word      (lane_word),
        .lane_byte (wdata_q[7:0]),
        .hi        (hi_q),
        .sext      (LB_SIGNED),
        .ext       (lane_ext),
        .merged    (lane_merged)
    );

    // memory port and handshake decode; reset suppresses any write in flight this cycle
    always_comb begin
        req_ready = (state == IDLE);
        mem_addr  = (state == IDLE) ? '0 : addr_q;
        mem_we    = !rst && (state == STORE || state == RMW_WR);
        mem_wdata = (state == STORE) ? wdata_q : (state == RMW_WR) ? lane_merged : '0;
    end

    // FSM, request latches and writeback registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= OP_LW;
            addr_q   <= '0;
            hi_q     <= 1'b0;
            wdata_q  <= '0;
            rd_q     <= '0;
            merge_q  <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    op_q    <= op_t'(req_op);
                    addr_q  <= req_addr;
                    hi_q    <= req_hi;
                    wdata_q <= req_wdata;
                    rd_q    <= req_rd;
                    state   <= (req_op == OP_SW) ? STORE : (req_op == OP_SB) ? RMW_RD : LOAD;
                end
                LOAD: begin
                    wb_data  <= (op_q == OP_LB) ? lane_ext : mem_rdata;
                    wb_rd    <= rd_q;
                    wb_valid <= 1'b1;
                    state    <= IDLE;
                end
                RMW_RD: begin
                    merge_q <= mem_rdata;
                    state   <= RMW_WR;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of the memory access stage against a behavioural data memory
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [7:0]  req_addr = 8'h00;
    logic        req_hi = 1'b0;
    logic [15:0] req_wdata = 16'h0000;
    logic [2:0]  req_rd = 3'd0;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        preload = 1'b1;
    logic [15:0] ram [0:255];
    int          checks = 0;
    int          errors = 0;

    mem_access_stage #(.DATA_W(16), .ADDR_W(8), .TAG_W(3), .LB_SIGNED(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_hi    (req_hi),
        .req_wdata (req_wdata),
        .req_rd    (req_rd),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'h0000;
            ram[0] <= 16'h00AB;
            ram[1] <= 16'h3C00;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic hi,
                         input logic [15:0] wdata, input logic [2:0] rd);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_hi    = hi;
        req_wdata = wdata;
        req_rd    = rd;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        preload = 1'b0;
        rst = 1'b0;
        tick();
        // reset held three cycles while a load is in flight
        issue(2'b00, 8'h00, 1'b0, 16'h0000, 3'd7);
        rst = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_ready", {15'd0, req_ready}, 16'd1);
        chk("rst_wb_valid", {15'd0, wb_valid}, 16'd0);
        chk("rst_mem_we", {15'd0, mem_we}, 16'd0);
        tick();
        chk("rst_wb_data", wb_data, 16'h0000);
        chk("rst_wb_rd", {13'd0, wb_rd}, 16'd0);
        chk("rst_mem_addr", {8'd0, mem_addr}, 16'd0);
        // LW addr 0 rd 5
        issue(2'b00, 8'h00, 1'b0, 16'h0000, 3'd5);
        chk("lw_c1_ready", {15'd0, req_ready}, 16'd0);
        chk("lw_c1_wb_valid", {15'd0, wb_valid}, 16'd0);
        chk("lw_c1_mem_we", {15'd0, mem_we}, 16'd0);
        tick();
        chk("lw_c2_wb_valid", {15'd0, wb_valid}, 16'd1);
        chk("lw_wb_data", wb_data, 16'h00AB);
        chk("lw_wb_rd", {13'd0, wb_rd}, 16'd5);
        chk("lw_c2_ready", {15'd0, req_ready}, 16'd1);
        tick();
        chk("lw_c3_wb_valid", {15'd0, wb_valid}, 16'd0);
        chk("lw_c3_wb_hold", wb_data, 16'h00AB);
        // LB low lane, signed
        issue(2'b10, 8'h00, 1'b0, 16'h0000, 3'd1);
        tick();
        chk("lb_lo_valid", {15'd0, wb_valid}, 16'd1);
        chk("lb_lo_data", wb_data, 16'hFFAB);
        chk("lb_lo_rd", {13'd0, wb_rd}, 16'd1);
        // LB high lane
        issue(2'b10, 8'h01, 1'b1, 16'h0000, 3'd2);
        chk("lb_hi_mem_addr", {8'd0, mem_addr}, 16'h0001);
        tick();
        chk("lb_hi_data", wb_data, 16'h003C);
        chk("lb_hi_rd", {13'd0, wb_rd}, 16'd2);
        // SB addr 1 low lane
        issue(2'b11, 8'h01, 1'b0, 16'hAA55, 3'd0);
        chk("sb_rd_ready", {15'd0, req_ready}, 16'd0);
        chk("sb_rd_mem_we", {15'd0, mem_we}, 16'd0);
        chk("sb_rd_mem_addr", {8'd0, mem_addr}, 16'h0001);
        tick();
        chk("sb_wr_ready", {15'd0, req_ready}, 16'd0);
        chk("sb_wr_mem_we", {15'd0, mem_we}, 16'd1);
        chk("sb_wr_mem_wdata", mem_wdata, 16'h3C55);
        tick();
        chk("sb_done_ready", {15'd0, req_ready}, 16'd1);
        chk("sb_done_mem_we", {15'd0, mem_we}, 16'd0);
        chk("sb_ram1", ram[1], 16'h3C55);
        // SB addr 0 high lane, then signed LB of that lane
        issue(2'b11, 8'h00, 1'b1, 16'h119A, 3'd0);
        tick();
        chk("sb_hi_mem_wdata", mem_wdata, 16'h9AAB);
        tick();
        chk("sb_hi_ram0", ram[0], 16'h9AAB);
        issue(2'b10, 8'h00, 1'b1, 16'h0000, 3'd3);
        tick();
        chk("lb_hi_signed", wb_data, 16'hFF9A);
        // SW addr 255 then LW addr 255 with valid held high
        issue(2'b01, 8'hFF, 1'b0, 16'hBEEF, 3'd0);
        chk("sw_mem_we", {15'd0, mem_we}, 16'd1);
        chk("sw_mem_addr", {8'd0, mem_addr}, 16'h00FF);
        chk("sw_mem_wdata", mem_wdata, 16'hBEEF);
        chk("sw_ready", {15'd0, req_ready}, 16'd0);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_addr  = 8'hFF;
        req_wdata = 16'h0000;
        req_rd    = 3'd6;
        tick();
        chk("sw_ram255", ram[255], 16'hBEEF);
        chk("sw_lw_ready", {15'd0, req_ready}, 16'd1);
        tick();
        req_valid = 1'b0;
        chk("sw_lw_accepted", {15'd0, req_ready}, 16'd0);
        chk("sw_lw_mem_addr", {8'd0, mem_addr}, 16'h00FF);
        tick();
        chk("sw_lw_valid", {15'd0, wb_valid}, 16'd1);
        chk("sw_lw_data", wb_data, 16'hBEEF);
        chk("sw_lw_rd", {13'd0, wb_rd}, 16'd6);
        // reset during RMW_WR of SB addr 2 drops the write
        issue(2'b11, 8'h02, 1'b0, 16'h0077, 3'd0);
        tick();
        chk("sb_rst_pre_we", {15'd0, mem_we}, 16'd1);
        rst = 1'b1;
        #1;
        chk("sb_rst_mem_we", {15'd0, mem_we}, 16'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("sb_rst_ram2", ram[2], 16'h0000);
        chk("sb_rst_ready", {15'd0, req_ready}, 16'd1);
        chk("sb_rst_wb_valid", {15'd0, wb_valid}, 16'd0);
        tick();
        chk("sb_rst_ram2_later", ram[2], 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
